uart_tx_mmio: RTL
=================

// Module: uart_tx_mmio
// PURPOSE
//  Memory-mapped UART transmitter. It is the responder on the load/store data bus
//  (cs/wr/mask/addr/data_wr/data_rd) that the pipeline's load/store unit initiates.
//  It sits beside data memory, selected by its own cs. Bytes written by the core are
//  queued in a small FIFO and serialised 8N1 on tx. Status and config are readable.
// PARAMETERS
//  FIFO_DEPTH   8    TX FIFO entries; power of two, >=2
//  DIV_W        16   width of baud divider register
//  DEFAULT_DIV  868  reset value of BAUDDIV (100 MHz / 115200)
// PORTS
//  clk      in   1   single clock, all state on posedge
//  rst      in   1   asynchronous, active-low reset (0 = reset)
//  cs       in   1   block select for this access cycle
//  wr       in   1   1 = write, 0 = read (qualified by cs)
//  mask     in   4   byte enables for write, bit i -> data_wr[8i+7:8i]
//  addr     in   32  byte address; only addr[3:2] decoded
//  data_wr  in   32  write data
//  data_rd  out  32  read data, combinational from addr, 0 when !cs
//  tx       out  1   serial output, idle high
// BEHAVIOUR
//  Register map (addr[3:2]):
//   00 TXDATA  W: if mask[0], push data_wr[7:0]; R: 0
//   01 STATUS  R: {28'b0, ovf, busy, empty, full}; W: mask[0]&data_wr[3] clears ovf
//   10 CTRL    RW [0] tx_en (reset 0); other bits read 0
//   11 BAUDDIV RW [DIV_W-1:0], byte-masked write, reset DEFAULT_DIV
//  - Writes take effect on the posedge where cs&wr; reads are same-cycle combinational.
//  - Reset: tx=1, FIFO empty, ovf=0, tx_en=0, BAUDDIV=DEFAULT_DIV, FSM IDLE.
//   Reset asserted mid-frame aborts the frame immediately (tx=1 asynchronously).
//  - FSM IDLE -> START -> DATA(x8) -> STOP -> IDLE.
//   IDLE: tx=1. If tx_en & !empty: pop head into shift reg. Latch div = max(BAUDDIV,1).
//    Go to START.
//   START: tx=0. DATA: tx=shift[0], LSB first, shift right each bit. STOP: tx=1.
//    Each bit lasts exactly div clocks.
//   After STOP, back-to-back frames have no extra idle cycle if FIFO non-empty.
//  - busy = (state != IDLE). Changing BAUDDIV mid-frame affects only the next frame.
//  - Clearing tx_en mid-frame: the current frame completes; no further pops.
//  - Push while full with no pop the same cycle: the byte is dropped and ovf is set (sticky).
//   Push while full with a same-cycle pop: the push is accepted.
//  - Push into an empty FIFO: the byte is visible to IDLE on the next cycle (no bypass).
//   So tx falls 2 clocks after the write edge.
//  - FIFO pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.
//   full = (count==FIFO_DEPTH).
// CONFIGURATION
//  UART_TX_IRQ_EN defined:
//   - Adds output irq (1b, reset 0) and CTRL[1] irq_en (RW, reset 0).
//   - irq = registered (irq_en & empty & !busy); level-sensitive.
//   - Cleared by pushing data or by clearing irq_en.
//  UART_TX_IRQ_EN undefined: no irq port; CTRL[1] reads 0 and ignores writes.
// STRUCTURE
//  uart_tx_pkg holds:
//   - register offset localparams (REG_TXDATA..REG_BAUDDIV)
//   - STATUS bit indices
//   - typedef enum logic [1:0] {TX_IDLE,TX_START,TX_DATA,TX_STOP} tx_state_t
//  Sub-module tx_fifo: sync FIFO, ports push/pop/din/dout/full/empty.
//   Instantiated once; serialiser and register decode stay in uart_tx_mmio.
// TESTING
//  1 Reset release, read STATUS -> data_rd=32'h2, tx=1. Read BAUDDIV -> 868.
//  2 BAUDDIV=4, CTRL=1, write TXDATA 0xA5 -> tx falls 2 clks later.
//    Then the bits are 0,1,0,1,0,0,1,0,1,1 each 4 clks (40 clks total); busy=1 throughout.
//  3 CTRL=0, 9 TXDATA writes -> STATUS.full=1 after 8th, 9th dropped, ovf=1.
//    Write STATUS 0x8 -> ovf=0. Set CTRL=1 -> exactly 8 frames with the correct bytes.
//  4 TXDATA write with mask=4'b1110 -> no push, empty stays 1. Read of TXDATA -> 0.
//  5 Mid-DATA, write BAUDDIV=8 -> current frame keeps 4-clk bits, next frame 8-clk bits.
//    Then assert rst mid-frame -> tx=1 at once, FIFO empty.
//  6 (UART_TX_IRQ_EN) irq_en=1, send one byte -> irq=0 while busy, 1 after STOP.
//    Push a byte -> irq drops.

Source files
------------

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : uart_tx_pkg                                                      |
// | Shared register offsets, STATUS/CTRL bit positions and serialiser states  |
// | for the memory-mapped UART transmitter.                                    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package uart_tx_pkg;

  // Register offsets as decoded from addr[3:2]
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_BAUDDIV = 2'd3;

  // STATUS bit indices
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  // CTRL bit indices
  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tx_fifo                                                          |
// | Synchronous FIFO holding bytes waiting for the serialiser. A push while    |
// | full is accepted only when a pop happens in the same cycle. No bypass:     |
// | a pushed entry becomes visible at dout on the following cycle.             |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_full_cnt = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; needs no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == c_full_cnt);
  assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_tx_mmio                                                     |
// | Memory-mapped 8N1 UART transmitter on the load/store data bus. Bytes       |
// | written to TXDATA are queued in tx_fifo and serialised LSB first on tx.    |
// | Optional feature macro: UART_TX_IRQ_EN (adds irq output and CTRL[1]).      |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module uart_tx_mmio
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd,
`ifdef UART_TX_IRQ_EN
  output logic        irq,
`endif
  output logic        tx
);

  tx_state_t        r_state, w_state_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic             r_tx, w_tx_nxt;
  logic             r_tx_en;
  logic             r_ovf;
  logic [DIV_W-1:0] r_baud;
  logic [DIV_W-1:0] w_baud_wr;
  logic [DIV_W-1:0] w_div_new;
  logic [1:0]       w_sel;
  logic             w_reg_wr;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_busy;
  logic             w_bit_end;
  logic             w_can_start;
  logic             w_irq_en_rd;
  logic [7:0]       w_fifo_dout;
  logic             w_unused_bits;

  assign w_sel       = addr[3:2];
  assign w_reg_wr    = cs & wr;
  assign w_push      = w_reg_wr & (w_sel == REG_TXDATA) & mask[0];
  assign w_busy      = (r_state != TX_IDLE);
  assign w_bit_end   = (r_cnt == r_div - DIV_W'(1));
  assign w_can_start = r_tx_en & ~w_empty;
  // A zero divider would never end a bit; treat it as one clock per bit
  assign w_div_new   = (r_baud == '0) ? DIV_W'(1) : r_baud;
  assign w_unused_bits = ^{addr, data_wr, mask};

  // Byte-lane merge for BAUDDIV writes
  for (genvar gi = 0; gi < DIV_W; gi++) begin : g_baud_bit
    assign w_baud_wr[gi] = mask[gi/8] ? data_wr[gi] : r_baud[gi];
  end

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (data_wr[7:0]),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // Serialiser state register; tx is registered so it trails the state by one clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= TX_IDLE;
      r_shift <= '0;
      r_div   <= DIV_W'(1);
      r_cnt   <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_div   <= w_div_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Next-state, bit timing and FIFO pop decision
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_div_nxt   = r_div;
    w_cnt_nxt   = w_bit_end ? '0 : r_cnt + DIV_W'(1);
    w_bit_nxt   = r_bit;
    w_tx_nxt    = 1'b1;
    w_pop       = 1'b0;
    case (r_state)
      TX_IDLE: begin
        w_cnt_nxt = '0;
        if (w_can_start) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_dout;
          w_div_nxt   = w_div_new;
          w_state_nxt = TX_START;
        end
      end
      TX_START: begin
        w_tx_nxt = 1'b0;
        if (w_bit_end) begin
          w_bit_nxt   = '0;
          w_state_nxt = TX_DATA;
        end
      end
      TX_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = TX_STOP;
        end
      end
      TX_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_bit_end) begin
          // Chain straight into the next frame when more data is queued
          if (w_can_start) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_dout;
            w_div_nxt   = w_div_new;
            w_state_nxt = TX_START;
          end else begin
            w_state_nxt = TX_IDLE;
          end
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  // Control/status registers written from the bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_en <= 1'b0;
      r_ovf   <= 1'b0;
      r_baud  <= DIV_W'(DEFAULT_DIV);
    end else begin
      if (w_push & w_full & ~w_pop) begin
        r_ovf <= 1'b1;
      end else if (w_reg_wr && w_sel == REG_STATUS && mask[0] && data_wr[STAT_OVF]) begin
        r_ovf <= 1'b0;
      end
      if (w_reg_wr && w_sel == REG_CTRL && mask[0]) r_tx_en <= data_wr[CTRL_TX_EN];
      if (w_reg_wr && w_sel == REG_BAUDDIV)         r_baud  <= w_baud_wr;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  // Interrupt enable and level interrupt raised when the transmitter has fully drained
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_reg_wr && w_sel == REG_CTRL && mask[0]) r_irq_en <= data_wr[CTRL_IRQ_EN];
      r_irq <= r_irq_en & w_empty & ~w_busy;
    end
  end

  assign w_irq_en_rd = r_irq_en;
  assign irq         = r_irq;
`else
  assign w_irq_en_rd = 1'b0;
`endif

  // Combinational read mux; zero when not selected
  always_comb begin
    data_rd = '0;
    if (cs) begin
      case (w_sel)
        REG_STATUS:  data_rd = {28'd0, r_ovf, w_busy, w_empty, w_full};
        REG_CTRL:    data_rd = {30'd0, w_irq_en_rd, r_tx_en};
        REG_BAUDDIV: data_rd = 32'(r_baud);
        default:     data_rd = '0;
      endcase
    end
  end

  assign tx = r_tx;

endmodule
`default_nettype wire
